// File: rtl/mpsoc_termination_monitor.sv
// mpsoc_termination_monitor
// Watches per-core termination and retire strobes across all MPSoC tiles and
// reports a normal completion after a drain window, or a watchdog timeout.
// Every output is registered, so the block can drive an FPGA status register.

module mpsoc_termination_monitor #(
    parameter int NUM_CORES      = 8,
    parameter int CNT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int DRAIN_CYCLES   = 16,
    parameter int IDX_WIDTH      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [NUM_CORES-1:0] core_mask,
    input  logic [NUM_CORES-1:0] termination,
    input  logic [NUM_CORES-1:0] trace_valid,
    output logic [1:0]           state,
    output logic [NUM_CORES-1:0] terminated,
    output logic [IDX_WIDTH-1:0] first_core,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic                 done,
    output logic                 timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // A zero timeout turns the watchdog off; WD_LAST is the final idle count
    // before expiry.
    localparam bit                 WD_ENABLED = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_WIDTH-1:0] WD_LAST    = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] DRAIN_LOAD = CNT_WIDTH'(DRAIN_CYCLES);

    state_t               state_q, state_d;
    logic [NUM_CORES-1:0] mask_q, mask_d;
    logic [NUM_CORES-1:0] terminated_q, terminated_d;
    logic [IDX_WIDTH-1:0] first_core_q, first_core_d;
    logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
    logic [CNT_WIDTH-1:0] wdog_q, wdog_d;
    logic [CNT_WIDTH-1:0] drain_q, drain_d;
    logic                 done_q, done_d;
    logic                 timeout_q, timeout_d;

    logic [NUM_CORES-1:0] hit;
    logic [NUM_CORES-1:0] newTerm;
    logic [IDX_WIDTH-1:0] lowIdx;
    logic [CNT_WIDTH-1:0] cycleInc;
    logic                 activity;
    logic                 allTerm;

    // Masked termination decode, lowest-index priority pick and saturating count.
    always_comb begin
        hit      = termination & mask_q;
        newTerm  = hit & ~terminated_q;
        activity = (|(trace_valid & mask_q)) | (|newTerm);
        allTerm  = &((terminated_q | hit) | ~mask_q);
        cycleInc = (cycle_q == '1) ? cycle_q : cycle_q + 1'b1;
        lowIdx   = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                lowIdx = IDX_WIDTH'(i);
            end
        end
    end

    // Next-state logic; in RUN a completing termination takes priority over expiry.
    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        terminated_d = terminated_q;
        first_core_d = first_core_q;
        cycle_d      = cycle_q;
        wdog_d       = wdog_q;
        drain_d      = drain_q;
        done_d       = done_q;
        timeout_d    = timeout_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    mask_d  = core_mask;
                    wdog_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                terminated_d = terminated_q | hit;
                if ((terminated_q == '0) && (|hit)) begin
                    first_core_d = lowIdx;
                end
                cycle_d = cycleInc;
                if (activity || !WD_ENABLED) begin
                    wdog_d = '0;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
                if (allTerm) begin
                    state_d = DRAIN;
                    drain_d = DRAIN_LOAD;
                end else if (WD_ENABLED && !activity && (wdog_q == WD_LAST)) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end
            end
            DRAIN: begin
                cycle_d = cycleInc;
                if (drain_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and status registers with synchronous clear from any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mask_q       <= '0;
            terminated_q <= '0;
            first_core_q <= '0;
            cycle_q      <= '0;
            wdog_q       <= '0;
            drain_q      <= '0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            terminated_q <= terminated_d;
            first_core_q <= first_core_d;
            cycle_q      <= cycle_d;
            wdog_q       <= wdog_d;
            drain_q      <= drain_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
        end
    end

    assign state       = state_q;
    assign terminated  = terminated_q;
    assign first_core  = first_core_q;
    assign cycle_count = cycle_q;
    assign done        = done_q;
    assign timeout     = timeout_q;

endmodule
